// File: rtl/ctr8_seq.sv
// Job sequencer for one ctr8 accumulator: clears it, drives x=step for len cycles,
// then returns the final count and a wrap flag over a valid/ready handshake.
module ctr8_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_step,
  input  logic [7:0] cmd_len,
  input  logic       abort,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_wrap,
  output logic       busy,
  output logic [7:0] ctr_x,
  output logic       ctr_rst,
  input  logic [7:0] ctr_y
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] step_q, step_d;
  logic [8:0] rem_q, rem_d;
  logic       wrap_q, wrap_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_wrap_q, res_wrap_d;
  // Low during reset and until the first edge after release, so cmd_ready and
  // ctr_rst follow reset without a combinational path from the reset pin.
  logic       live_q;

  logic [8:0] sum;
  assign sum = {1'b0, ctr_y} + {1'b0, step_q};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    step_d     = step_q;
    rem_d      = rem_q;
    wrap_d     = wrap_q;
    res_data_d = res_data_q;
    res_wrap_d = res_wrap_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && live_q) begin
          step_d  = cmd_step;
          rem_d   = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        wrap_d  = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wrap_d = wrap_q | sum[8];
        rem_d  = rem_q - 9'd1;
        if (rem_q == 9'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        res_data_d = ctr_y;
        res_wrap_d = wrap_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every other transition and leaves the last result untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      res_data_d = res_data_q;
      res_wrap_d = res_wrap_q;
    end
  end

  // NOTE: state uses non-blocking assignments and every register, datapath included,
  // is cleared by the asynchronous reset so outputs are defined the moment reset drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      step_q     <= 8'd0;
      rem_q      <= 9'd0;
      wrap_q     <= 1'b0;
      res_data_q <= 8'd0;
      res_wrap_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      rem_q      <= rem_d;
      wrap_q     <= wrap_d;
      res_data_q <= res_data_d;
      res_wrap_q <= res_wrap_d;
      live_q     <= 1'b1;
    end
  end

  assign cmd_ready = live_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_data_q;
  assign res_wrap  = res_wrap_q;
  assign ctr_x     = (state_q == S_RUN) ? step_q : 8'd0;
  assign ctr_rst   = !live_q || (state_q == S_CLEAR);

endmodule
